// File: rtl/ram2k_word_reader.sv
// Burst reader that assembles 16-bit words from eight 2-bit reads of a 2048x2 RAM.
// First word is valid 9 cycles after acceptance and is held stable until out_ready.
module ram2k_word_reader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_len,
  output logic [10:0] ram_raddr,
  output logic        ram_re,
  output logic        ram_rclke,
  input  logic [1:0]  ram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  word;
  logic [7:0]  remain;
  logic [2:0]  iss_k;
  logic [2:0]  cap_k;
  logic        rd_pend;
  logic [2:0]  slot;

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign ram_rclke = ram_re;
  assign out_last  = out_valid && (remain == 8'd0);
  assign slot      = LSB_FIRST ? cap_k : (3'd7 - cap_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= 8'd0;
      remain    <= 8'd0;
      iss_k     <= 3'd0;
      cap_k     <= 3'd0;
      rd_pend   <= 1'b0;
      ram_re    <= 1'b0;
      ram_raddr <= 11'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      // RAM data arrives one cycle after the edge that sampled ram_re.
      rd_pend <= ram_re;
      if (rd_pend) begin
        out_data[{slot, 1'b0} +: 2] <= ram_rdata;
        cap_k <= cap_k + 3'd1;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            word      <= req_addr;
            remain    <= req_len;
            ram_re    <= 1'b1;
            ram_raddr <= {req_addr, 3'd0};
            iss_k     <= 3'd0;
            cap_k     <= 3'd0;
            state     <= FETCH;
          end
        end

        FETCH: begin
          if (ram_re) begin
            if (iss_k == 3'd7) begin
              ram_re <= 1'b0;
            end else begin
              iss_k     <= iss_k + 3'd1;
              ram_raddr <= {word, iss_k + 3'd1};
            end
          end
          if (rd_pend && (cap_k == 3'd7)) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remain == 8'd0) begin
              state <= IDLE;
            end else begin
              // Next word's fetch starts on the handshake edge itself.
              remain    <= remain - 8'd1;
              word      <= word + 8'd1;
              ram_re    <= 1'b1;
              ram_raddr <= {word + 8'd1, 3'd0};
              iss_k     <= 3'd0;
              cap_k     <= 3'd0;
              state     <= FETCH;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
